mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter: n, default 8, operand width of the shift-add multiplier being sequenced.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one multiplication; sampled only in IDLE.
REQ-005 AQ  input  2n  product/accumulator word from the A/Q register stage.
REQ-006 ack  input  1  consumer accepts product; clears valid.
REQ-007 resetout  output  1  one-cycle pulse: clear A, load multiplier into Q.
REQ-008 ready  output  1  low only while the A/Q stage must add-and-shift.
REQ-009 busy  output  1  high in LOAD, RUN and DONE.
REQ-010 product  output  2n  captured 2n-bit result.
REQ-011 valid  output  1  product holds an unacknowledged result.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN and DONE, with a step counter of width clog2(n)+1.
REQ-013 IDLE: resetout=0, ready=1, busy=0; start=1 -> LOAD; start=0 -> stay.
REQ-014 LOAD: resetout=1, ready=1, counter<=0; unconditionally -> RUN.
REQ-015 RUN: ready=0, counter increments each cycle; counter==n-1 -> DONE, else stay; RUN lasts exactly n cycles.
REQ-016 DONE: ready=1, product<=AQ, valid<=1; unconditionally -> IDLE.
REQ-017 Latency: start sampled at edge 0 -> resetout high cycle 1, ready low cycles 2..n+1, DONE cycle n+2, valid/product visible cycle n+3.
REQ-018 start outside IDLE SHALL be ignored (no queuing).
REQ-019 valid SHALL stay 1 until ack=1 is sampled while valid=1; it then clears on the next edge.
REQ-020 ack while valid=0 SHALL have no effect.
REQ-021 Simultaneous DONE capture and ack: capture wins; product updates and valid stays 1.
REQ-022 A capture while valid=1 and unacknowledged SHALL overwrite product.
REQ-023 start in IDLE SHALL be accepted regardless of valid.
REQ-024 product SHALL change only in DONE.

Reset
REQ-025 reset=1 SHALL force IDLE, counter=0, resetout=0, ready=1, busy=0, product=0 and valid=0 on the next edge.
REQ-026 reset SHALL take priority over every other input, including mid-RUN and in DONE; no capture SHALL occur in that cycle.

Configuration
REQ-027 The macro MULT_SEQ_OVERRUN_EN SHALL select overrun detection.
REQ-028 Defined: add output overrun (1 bit), sticky; set when a DONE capture occurs while valid=1 and ack=0; cleared only by reset.
REQ-029 Undefined: the overrun port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package mult_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DONE) and the default width constant used for n.
REQ-031 The step counter SHALL be one sub-module, mult_cnt, with clear, enable and terminal-count (== n-1) output; everything else stays in mult_seq.

Verification (n=8; bench models the A/Q stage)
REQ-032 Stimulus: after reset, 1-cycle start, multiplier 13, multiplicand 11 -> resetout high cycle 1; ready low cycles 2-9; valid rises cycle 11; product=143.
REQ-033 Stimulus: start held high for 20 cycles -> exactly two multiplications; the second begins in the cycle after the first returns to IDLE; no start is queued.
REQ-034 Stimulus: 255x255 with ack never asserted, then a second run 2x3 -> product goes 65025 then 6; valid stays 1; with MULT_SEQ_OVERRUN_EN, overrun=1 after the second capture.
REQ-035 Stimulus: ack asserted in the DONE cycle of a second run while the first result is pending -> product updates and valid remains 1.
REQ-036 Stimulus: reset pulsed at RUN counter=4 -> next cycle IDLE, ready=1, valid=0, product=0; a following start gives the correct result.
REQ-037 Stimulus: 0x0 and 1x255 -> products 0 and 255, same cycle timing as REQ-032.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package mult_pkg;

  localparam int unsigned MULT_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Step counter must hold n-1 for any n, including powers of two.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_cnt.sv
// Step counter for the multiplier sequencer: clear, enable, terminal count at n-1.
module mult_cnt
  import mult_pkg::*;
#(
  parameter int unsigned n  = MULT_N_DEFAULT,
  parameter int unsigned CW = cnt_width(n)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state is written with <= so every flop samples pre-edge values; reset is synchronous here.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CW'(n - 1));

endmodule

// File: rtl/mult_seq.sv
// Sequencer for an n-bit shift-add multiplier: drives the A/Q stage and captures its product.
// Optional sticky overrun output is enabled by defining MULT_SEQ_OVERRUN_EN.
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned n = MULT_N_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [2*n-1:0] AQ,
  input  logic           ack,
  output logic           resetout,
  output logic           ready,
  output logic           busy,
  output logic [2*n-1:0] product,
`ifdef MULT_SEQ_OVERRUN_EN
  output logic           valid,
  output logic           overrun
`else
  output logic           valid
`endif
);

  state_e         state_q,    state_d;
  logic           resetout_q, resetout_d;
  logic           ready_q,    ready_d;
  logic           busy_q,     busy_d;
  logic [2*n-1:0] product_q,  product_d;
  logic           valid_q,    valid_d;
  logic           cnt_tc;

  mult_cnt #(.n(n)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == LOAD),
    .enable (state_q == RUN),
    .tc     (cnt_tc)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    valid_d   = valid_q;

    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (cnt_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A capture in DONE outranks a simultaneous acknowledge.
    if (state_q == DONE) begin
      product_d = AQ;
      valid_d   = 1'b1;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    resetout_d = (state_d == LOAD);
    ready_d    = (state_d != RUN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      resetout_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      product_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      resetout_q <= resetout_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      product_q  <= product_d;
      valid_q    <= valid_d;
    end
  end

`ifdef MULT_SEQ_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | ((state_q == DONE) && valid_q && !ack);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  assign resetout = resetout_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign product  = product_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq (n=8) with a behavioural A/Q shift-add stage.
// Define MULT_SEQ_OVERRUN_EN to also check the overrun output.
module tb_mult_seq;

  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           ack;
  logic [2*N-1:0] aq;
  logic           resetout;
  logic           ready;
  logic           busy;
  logic [2*N-1:0] product;
  logic           valid;
`ifdef MULT_SEQ_OVERRUN_EN
  logic           overrun;
`endif

  mult_seq #(.n(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .AQ       (aq),
    .ack      (ack),
    .resetout (resetout),
    .ready    (ready),
    .busy     (busy),
    .product  (product),
`ifdef MULT_SEQ_OVERRUN_EN
    .valid    (valid),
    .overrun  (overrun)
`else
    .valid    (valid)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // A/Q stage: load on resetout, add-and-shift whenever ready is low.
  logic [N-1:0] mcand  = '0;
  logic [N-1:0] mplier = '0;
  logic [N-1:0] a_r    = '0;
  logic [N-1:0] q_r    = '0;
  assign aq = {a_r, q_r};

  always @(posedge clock) begin
    logic [N:0] sum;
    if (resetout) begin
      a_r <= '0;
      q_r <= mplier;
    end else if (!ready) begin
      sum = {1'b0, a_r} + (q_r[0] ? {1'b0, mcand} : {(N+1){1'b0}});
      a_r <= sum[N:1];
      q_r <= {sum[0], q_r[N-1:1]};
    end
  end

  typedef struct {
    logic [2*N-1:0] p;
    int             c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a capture shows up as busy falling without a reset behind it.
  logic prev_busy = 1'b0;
  logic prev_rst  = 1'b1;

  always @(negedge clock) begin
    if (prev_busy && !busy && !prev_rst) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_capture: product %0d appeared, expected no result (cycle %0d)",
                 product, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("product", product, mon_e.p);
        check("capture_cycle", cyc, mon_e.c);
        check("valid_at_capture", valid, 1);
      end
    end
    prev_busy <= busy;
    prev_rst  <= reset;
  end

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  // Called just after an edge with the DUT idle; returns the edge count that sampled start.
  task automatic issue(input logic [N-1:0] mc, input logic [N-1:0] mp,
                       input logic [2*N-1:0] ex, input bit push, output int s);
    mcand  = mc;
    mplier = mp;
    start  = 1'b1;
    step(1);
    s     = cyc;
    start = 1'b0;
    if (push) sb.push_back('{ex, s + 10});
  endtask

  task automatic run(input logic [N-1:0] mc, input logic [N-1:0] mp,
                     input logic [2*N-1:0] ex, input logic [2*N-1:0] prev, input bit timed);
    int s;
    issue(mc, mp, ex, 1'b1, s);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (timed) begin
        check($sformatf("resetout_c%0d", k), resetout, (k == 1));
        check($sformatf("ready_c%0d", k), ready, (k < 2 || k > 9));
        check($sformatf("busy_c%0d", k), busy, (k <= 10));
        if (k <= 10) check($sformatf("product_hold_c%0d", k), product, prev);
      end
    end
    step(1);
  endtask

  task automatic ack_clear(input logic [2*N-1:0] exp_p);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    @(negedge clock);
    check("valid_after_ack", valid, 0);
    check("product_after_ack", product, exp_p);
    step(1);
  endtask

  initial begin
    int s;
    reset = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    step(3);
    @(negedge clock);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resetout", resetout, 0);
    check("rst_valid", valid, 0);
    check("rst_product", product, 0);
`ifdef MULT_SEQ_OVERRUN_EN
    check("rst_overrun", overrun, 0);
`endif
    step(1);
    reset = 1'b0;
    step(1);

    // 11 x 13 with full cycle timing
    run(8'd11, 8'd13, 16'd143, 16'd0, 1'b1);
    ack_clear(16'd143);
    // ack while nothing is pending changes nothing
    ack_clear(16'd143);

    // corner operands
    run(8'd0, 8'd0, 16'd0, 16'd143, 1'b1);
    ack_clear(16'd0);
    run(8'd255, 8'd1, 16'd255, 16'd0, 1'b1);
    ack_clear(16'd255);

    // start held 20 cycles: two back-to-back runs, nothing queued
    mcand  = 8'd9;
    mplier = 8'd7;
    ack    = 1'b1;
    start  = 1'b1;
    step(1);
    s = cyc;
    sb.push_back('{16'd63, s + 10});
    sb.push_back('{16'd63, s + 21});
    step(19);
    start = 1'b0;
    step(20);
    ack = 1'b0;
    @(negedge clock);
    check("held_start_idle", busy, 0);
    check("held_start_drained", sb.size(), 0);
    check("held_start_valid", valid, 0);
`ifdef MULT_SEQ_OVERRUN_EN
    check("held_start_overrun", overrun, 0);
`endif
    step(1);

    // unacknowledged result overwritten by a second capture
    run(8'd255, 8'd255, 16'd65025, 16'd63, 1'b1);
    run(8'd3, 8'd2, 16'd6, 16'd65025, 1'b1);
    @(negedge clock);
    check("overwrite_valid", valid, 1);
    check("overwrite_product", product, 6);
`ifdef MULT_SEQ_OVERRUN_EN
    check("overrun_set", overrun, 1);
`endif
    step(1);

    // ack in the DONE cycle while the previous result is still pending
    issue(8'd5, 8'd5, 16'd25, 1'b1, s);
    step(9);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    @(negedge clock);
    check("done_ack_valid", valid, 1);
    check("done_ack_product", product, 25);
    step(1);
    @(negedge clock);
    check("done_ack_valid_hold", valid, 1);
    step(1);

    // reset while the step counter is at 4
    issue(8'd4, 8'd4, 16'd16, 1'b0, s);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clock);
    check("midrun_rst_ready", ready, 1);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_resetout", resetout, 0);
    check("midrun_rst_valid", valid, 0);
    check("midrun_rst_product", product, 0);
`ifdef MULT_SEQ_OVERRUN_EN
    check("midrun_rst_overrun", overrun, 0);
`endif
    step(1);
    run(8'd7, 8'd6, 16'd42, 16'd0, 1'b1);

    step(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
